// File: rtl/ic_bd_pkg.sv
// Shared constants and arithmetic helpers for the 8-point forward/inverse BinDCT datapath.
package ic_bd_pkg;

    localparam int NPT = 8;

    // Lane of coefficient Xk inside a packed coefficient row, X0 in the LSBs.
    localparam int LANE_OF_X [NPT] = '{32'sd0, 32'sd1, 32'sd2, 32'sd3,
                                        32'sd4, 32'sd5, 32'sd6, 32'sd7};

    function automatic logic signed [63:0] ashr(input logic signed [63:0] v,
                                                 input int unsigned sh);
        ashr = v >>> sh;
    endfunction

    function automatic logic signed [63:0] sat_to(input logic signed [63:0] v,
                                                   input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 32'd1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 32'd1));
        if (v > hi) begin
            sat_to = hi;
        end else if (v < lo) begin
            sat_to = lo;
        end else begin
            sat_to = v;
        end
    endfunction

endpackage

// File: rtl/ic_bd_pipe_ctrl.sv
// Three-stage valid/advance control with row-count tag and last-flag sideband.
module ic_bd_pipe_ctrl (
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    input  logic in_last,
    input  logic out_ready,
    output logic in_ready,
    output logic ld_a,
    output logic ld_b,
    output logic ld_c,
    output logic out_valid,
    output logic out_last,
    output logic out_blk_end
);

    logic       va_r, vb_r, vc_r;
    logic       adv_a_s, adv_b_s, adv_c_s;
    logic [2:0] row_cnt_r, tag_a_r, tag_b_r;
    logic       last_a_r, last_b_r, last_c_r, blk_end_c_r;

    // Backpressure ripples from the output toward the input in one cycle.
    always_comb begin
        adv_c_s = !vc_r || out_ready;
        adv_b_s = !vb_r || adv_c_s;
        adv_a_s = !va_r || adv_b_s;
    end

    assign in_ready    = adv_a_s;
    assign ld_a        = in_valid && adv_a_s;
    assign ld_b        = adv_b_s && va_r;
    assign ld_c        = adv_c_s && vb_r;
    assign out_valid   = vc_r;
    assign out_last    = last_c_r;
    assign out_blk_end = blk_end_c_r;

    // Stage valid bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            va_r <= 1'b0;
            vb_r <= 1'b0;
            vc_r <= 1'b0;
        end else begin
            if (adv_a_s) va_r <= in_valid;
            if (adv_b_s) vb_r <= va_r;
            if (adv_c_s) vc_r <= vb_r;
        end
    end

    // Row counter and sideband tags move only with their row.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_cnt_r   <= 3'd0;
            tag_a_r     <= 3'd0;
            tag_b_r     <= 3'd0;
            last_a_r    <= 1'b0;
            last_b_r    <= 1'b0;
            last_c_r    <= 1'b0;
            blk_end_c_r <= 1'b0;
        end else begin
            if (ld_a) begin
                row_cnt_r <= row_cnt_r + 3'd1;
                tag_a_r   <= row_cnt_r;
                last_a_r  <= in_last;
            end
            if (ld_b) begin
                tag_b_r  <= tag_a_r;
                last_b_r <= last_a_r;
            end
            if (ld_c) begin
                last_c_r    <= last_b_r;
                blk_end_c_r <= (tag_b_r == 3'd7);
            end
        end
    end

endmodule

// File: rtl/ic_bd_bindct_1d_pipe.sv
// 8-point 1-D forward BinDCT (C7 lifting), three flow-controlled stages,
// optional saturation to the output width and block-end tagging.
module ic_bd_bindct_1d_pipe
    import ic_bd_pkg::*;
#(
    parameter int IN_W  = 12,
    parameter int OUT_W = 16,
    parameter int SAT   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*IN_W-1:0]    x,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*OUT_W-1:0]   y,
    output logic                 out_last,
    output logic                 out_blk_end,
    output logic                 out_sat
);

    localparam int W = IN_W + 4;

    function automatic logic signed [W-1:0] sr(input logic signed [W-1:0] v,
                                               input int unsigned s);
        logic signed [63:0] e;
        e  = {{(64-W){v[W-1]}}, v};
        sr = W'(ashr(e, s));
    endfunction

    logic ld_a_s, ld_b_s, ld_c_s;

    logic signed [W-1:0] xs_s     [NPT];
    logic signed [W-1:0] a_nxt_s  [NPT];
    logic signed [W-1:0] a_r      [NPT];
    logic signed [W-1:0] p_s, q_s;
    logic signed [W-1:0] b_nxt_s  [NPT];
    logic signed [W-1:0] b_r      [NPT];
    logic signed [W-1:0] xc_s     [NPT];
    logic signed [63:0]  ext_s, clip_s;
    logic [8*OUT_W-1:0]  y_nxt_s, y_r;
    logic                sat_nxt_s, sat_r;

    ic_bd_pipe_ctrl u_ctrl (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .out_ready   (out_ready),
        .in_ready    (in_ready),
        .ld_a        (ld_a_s),
        .ld_b        (ld_b_s),
        .ld_c        (ld_c_s),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .out_blk_end (out_blk_end)
    );

    // Stage A butterflies; x0 sits in the MSBs of the input row.
    always_comb begin
        for (int i = 0; i < NPT; i++) begin
            xs_s[i] = {{4{x[(NPT-i)*IN_W-1]}}, x[(NPT-i)*IN_W-1 -: IN_W]};
        end
        a_nxt_s[0] = xs_s[0] + xs_s[7];
        a_nxt_s[7] = xs_s[0] - xs_s[7];
        a_nxt_s[1] = xs_s[1] + xs_s[6];
        a_nxt_s[6] = xs_s[1] - xs_s[6];
        a_nxt_s[2] = xs_s[2] + xs_s[5];
        a_nxt_s[5] = xs_s[2] - xs_s[5];
        a_nxt_s[3] = xs_s[3] + xs_s[4];
        a_nxt_s[4] = xs_s[3] - xs_s[4];
    end

    // Stage B: even butterflies plus the odd-part lifting pair.
    always_comb begin
        p_s = sr(a_r[6], 32'd1) + sr(a_r[6], 32'd3) - sr(a_r[5], 32'd1)
              - sr(a_r[5], 32'd2) - sr(a_r[5], 32'd6);
        q_s = a_r[6] + sr(a_r[5], 32'd2) + sr(a_r[5], 32'd3);
        b_nxt_s[0] = a_r[0] + a_r[3];
        b_nxt_s[1] = a_r[1] + a_r[2];
        b_nxt_s[2] = a_r[1] - a_r[2];
        b_nxt_s[3] = a_r[0] - a_r[3];
        b_nxt_s[4] = a_r[4] + p_s;
        b_nxt_s[5] = a_r[4] - p_s;
        b_nxt_s[6] = a_r[7] - q_s;
        b_nxt_s[7] = a_r[7] + q_s;
    end

    // Stage C coefficients followed by conversion to OUT_W.
    always_comb begin
        xc_s[0] = b_r[0] + b_r[1];
        xc_s[4] = sr(b_r[0], 32'd1) - sr(b_r[1], 32'd1);
        xc_s[6] = b_r[2] - sr(b_r[3], 32'd2) - sr(b_r[3], 32'd3);
        xc_s[2] = sr(b_r[2], 32'd2) + sr(b_r[2], 32'd3) + b_r[3]
                  - sr(b_r[3], 32'd3) - sr(b_r[3], 32'd6);
        xc_s[7] = b_r[4] - sr(b_r[7], 32'd3);
        xc_s[5] = b_r[5] + b_r[6] - sr(b_r[6], 32'd3);
        xc_s[3] = sr(b_r[6], 32'd1) + sr(b_r[6], 32'd4) - sr(b_r[5], 32'd1);
        xc_s[1] = b_r[7];
        ext_s     = 64'sd0;
        clip_s    = 64'sd0;
        y_nxt_s   = '0;
        sat_nxt_s = 1'b0;
        for (int k = 0; k < NPT; k++) begin
            ext_s  = {{(64-W){xc_s[k][W-1]}}, xc_s[k]};
            clip_s = sat_to(ext_s, OUT_W);
            if (SAT != 0) begin
                y_nxt_s[LANE_OF_X[k]*OUT_W +: OUT_W] = clip_s[OUT_W-1:0];
                sat_nxt_s = sat_nxt_s | (clip_s != ext_s);
            end else begin
                y_nxt_s[LANE_OF_X[k]*OUT_W +: OUT_W] = ext_s[OUT_W-1:0];
            end
        end
    end

    // Stage A registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NPT; i++) a_r[i] <= '0;
        end else if (ld_a_s) begin
            a_r <= a_nxt_s;
        end
    end

    // Stage B registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NPT; i++) b_r[i] <= '0;
        end else if (ld_b_s) begin
            b_r <= b_nxt_s;
        end
    end

    // Stage C registers drive the outputs directly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_r   <= '0;
            sat_r <= 1'b0;
        end else if (ld_c_s) begin
            y_r   <= y_nxt_s;
            sat_r <= sat_nxt_s;
        end
    end

    assign y       = y_r;
    assign out_sat = (SAT != 0) ? sat_r : 1'b0;

endmodule

// File: doc/ic_bd_bindct_1d_pipe.md
# ic_bd_bindct_1d_pipe

Parametrised, flow-controlled 8-point 1-D forward BinDCT (C7 lifting, shift-add only) for the JPEG compression datapath. Sits between the row/column buffer and the transpose memory, and is instantiated twice (row pass, column pass) with different widths. It generalises the fixed 12→16-bit stage:
- input/output widths are parameters;
- it has a valid/ready handshake with full backpressure;
- it optionally saturates to the output width;
- it tags the eighth row of every 8×8 block.

## Interface
Parameters:
- IN_W, 12, signed width of each input sample.
- OUT_W, 16, signed width of each output coefficient.
- SAT, 1, 1 = saturate each coefficient to OUT_W; 0 = truncate to OUT_W LSBs.

Ports:
- clk  in  1  rising-edge clock, the only clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input row valid.
- in_ready  out  1  block can accept a row this cycle.
- x  in  8*IN_W  samples; x0 in MSBs … x7 in LSBs.
- in_last  in  1  sideband tag carried with the row (frame end).
- out_valid  out  1  output row valid.
- out_ready  in  1  downstream accepts.
- y  out  8*OUT_W  coefficients; X0 in LSBs, then X1 … X7 toward the MSBs.
- out_last  out  1  in_last of this row, delayed.
- out_blk_end  out  1  high with the 8th row of each block.
- out_sat  out  1  at least one coefficient of this row clipped (SAT=1 only; tied 0 otherwise).

## Operation
- Internal width is W = IN_W+4. Inputs are sign-extended to W.
- All shifts are arithmetic right shifts (floor).
- All adds and subtracts wrap in W bits.
- Stage A, registered on accept:
  - a0=x0+x7, a7=x0−x7
  - a1=x1+x6, a6=x1−x6
  - a2=x2+x5, a5=x2−x5
  - a3=x3+x4, a4=x3−x4
- Stage B, registered. Combinational from A:
  - p = (a6>>1)+(a6>>3)−(a5>>1)−(a5>>2)−(a5>>6)
  - q = a6+(a5>>2)+(a5>>3)
- Stage B registers:
  - b0=a0+a3, b1=a1+a2, b2=a1−a2, b3=a0−a3
  - b4=a4+p, b5=a4−p, b6=a7−q, b7=a7+q
- Stage C, registered:
  - X0=b0+b1
  - X4=(b0>>1)−(b1>>1)
  - X6=b2−(b3>>2)−(b3>>3)
  - X2=(b2>>2)+(b2>>3)+b3−(b3>>3)−(b3>>6)
  - X7=b4−(b7>>3)
  - X5=b5+b6−(b6>>3)
  - X3=(b6>>1)+(b6>>4)−(b5>>1)
  - X1=b7
- Output conversion: each W-bit X is clamped to [−2^(OUT_W−1), 2^(OUT_W−1)−1] when SAT=1; otherwise its low OUT_W bits are taken. If OUT_W ≥ W the value is sign-extended and clipping never occurs.
- Row counter (3 bits) increments on each accepted row and wraps 7→0. Its value travels down the pipe; out_blk_end = (tag==7).
- in_last, the row-count tag and the saturation flag travel in lockstep with the data.

## Timing
- Three pipeline stages, each with its own valid bit: vA, vB, vC. out_valid = vC.
- Stage C advances when !vC or out_ready. Stage B advances when !vB or C advances. Stage A advances the same way with respect to B.
- in_ready = !vA or A advances. It is combinational from out_ready (no skid buffer).
- A row is accepted on a clock edge when in_valid && in_ready.
- Latency: a row accepted at edge N appears at out_valid/y after edge N+2, i.e. it is visible for the cycle following edge N+2. Throughput is 1 row/cycle.
- A stalled stage holds its data and flags unchanged. y is stable while out_valid && !out_ready.
- An accepted input plus out_ready in the same cycle on a full pipe moves every stage; no bubble.
- Reset (any time, asynchronous):
  - vA/vB/vC=0, all data registers 0, row counter 0.
  - Outputs after reset: out_valid=0, y=0, out_last=0, out_blk_end=0, out_sat=0, in_ready=1.
  - In-flight rows are discarded.
- Data registers capture only when their stage advances with valid input, giving no spurious toggling.

## Structure
- Package ic_bd_pkg holds:
  - the function for the W-bit arithmetic right shift;
  - the saturate-to-OUT_W function;
  - localparam NPT=8;
  - the output lane order (X0..X7 LSB→MSB) as constants shared with the transpose block.
- One sub-module, ic_bd_pipe_ctrl: the per-stage valid/advance logic and the sideband shift (last, blk tag). It is reused by the inverse stage later.

## Test plan
- Defaults, all x=100, out_ready=1 → after 3 cycles y: X0=800, X1..X7=0, out_sat=0.
- Impulse x0=64, others 0 → X0=64, X1=64, X2=55, X3=36, X4=32, X5=56, X6=−24, X7=−8.
- IN_W=12, OUT_W=12, SAT=1, all x=2047 → X0=2047, out_sat=1. Same with SAT=0 → X0 = low 12 bits of 16376 = −8.
- Stream 16 random rows with out_ready toggled pseudo-randomly → output order and data match the golden model, no loss or duplication, and y is stable during stalls. out_blk_end is high on rows 8 and 16.
- out_ready=0 with a full pipe → in_ready=0 after 3 accepted rows; releasing out_ready drains one row per cycle.
- Assert reset mid-stream with 2 rows in flight → out_valid drops immediately and all outputs are 0. After release, the first new row is tagged as row 0 of its block.
